// File: rtl/uart_pkg.sv
// Shared UART receiver types: FSM state encoding, parity-mode codes and
// parameter legality helpers used at elaboration.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rxState_e;

    // Mode 2'b11 is deliberately not listed; it behaves like PAR_NONE.
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    function automatic bit dataBitsLegal(input int n);
        return (n >= 5) && (n <= 9);
    endfunction

    function automatic bit oversampleLegal(input int n);
        return (n >= 8) && (n <= 32) && ((n % 2) == 0);
    endfunction

    function automatic bit stopBitsLegal(input int n);
        return (n == 1) || (n == 2);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an idle-high asynchronous line; resets to 1 so
// a reset never looks like a start bit.
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] sync_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_d};
        end
    end

    assign o_q = sync_q[1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver with valid/ready delivery and error status.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting on every bit decision.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rx,
    input  logic                 i_tick,
    input  logic [1:0]           i_parity_mode,
    input  logic                 i_ready,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_M1   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1   = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    if (!dataBitsLegal(DATA_BITS)) begin : gen_bad_data_bits
        $error("uart_rx_cfg: DATA_BITS must be 5..9");
    end
    if (!oversampleLegal(OVERSAMPLE)) begin : gen_bad_oversample
        $error("uart_rx_cfg: OVERSAMPLE must be even, 8..32");
    end
    if (!stopBitsLegal(STOP_BITS)) begin : gen_bad_stop_bits
        $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end

    rxState_e             state_q, state_d;
    logic [TW-1:0]        tickCnt_q, tickCnt_d;
    logic [3:0]           bitCnt_q, bitCnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [1:0]           mode_q, mode_d;
    logic                 parErrPend_q, parErrPend_d;
    logic                 frameErrPend_q, frameErrPend_d;
    logic                 frameDone_q, frameDone_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 parErr_q, parErr_d;
    logic                 frameErr_q, frameErr_d;
    logic                 overrun_q, overrun_d;

    logic rxSync;
    logic bitVal;
    logic atHalf;
    logic atCentre;
    logic expPar;

    uart_rx_sync uSync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_rx),
        .o_q     (rxSync)
    );

`ifdef UART_RX_MAJORITY_EN
    // The two previous tick samples plus the current one form the vote.
    logic [1:0] hist_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hist_q <= 2'b11;
        end else if (i_tick) begin
            hist_q <= {hist_q[0], rxSync};
        end
    end

    assign bitVal = (rxSync & hist_q[0]) | (rxSync & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign bitVal = rxSync;
`endif

    assign atHalf   = i_tick && (tickCnt_q == HALF_M1);
    assign atCentre = i_tick && (tickCnt_q == FULL_M1);
    assign expPar   = (^shift_q) ^ (mode_q == PAR_ODD);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_tick && !rxSync) state_d = ST_START;
            end
            ST_START: begin
                if (atHalf) state_d = bitVal ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (atCentre && (bitCnt_q == LAST_DATA)) begin
                    state_d = ((mode_q == PAR_EVEN) || (mode_q == PAR_ODD)) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (atCentre) state_d = ST_STOP;
            end
            ST_STOP: begin
                // Leaving at the centre of the last stop bit catches a back-to-back start.
                if (atCentre && (bitCnt_q == LAST_STOP)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tickCnt_d      = tickCnt_q;
        bitCnt_d       = bitCnt_q;
        shift_d        = shift_q;
        mode_d         = mode_q;
        parErrPend_d   = parErrPend_q;
        frameErrPend_d = frameErrPend_q;
        frameDone_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tickCnt_d = '0;
                bitCnt_d  = '0;
                if (i_tick && !rxSync) begin
                    parErrPend_d   = 1'b0;
                    frameErrPend_d = 1'b0;
                end
            end
            ST_START: begin
                if (atHalf) begin
                    tickCnt_d = '0;
                    bitCnt_d  = '0;
                    if (!bitVal) mode_d = i_parity_mode;
                end else if (i_tick) begin
                    tickCnt_d = tickCnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (atCentre) begin
                    shift_d   = {bitVal, shift_q[DATA_BITS-1:1]};
                    tickCnt_d = '0;
                    bitCnt_d  = (bitCnt_q == LAST_DATA) ? 4'd0 : bitCnt_q + 4'd1;
                end else if (i_tick) begin
                    tickCnt_d = tickCnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (atCentre) begin
                    if (bitVal != expPar) parErrPend_d = 1'b1;
                    tickCnt_d = '0;
                end else if (i_tick) begin
                    tickCnt_d = tickCnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (atCentre) begin
                    if (!bitVal) frameErrPend_d = 1'b1;
                    tickCnt_d = '0;
                    bitCnt_d  = bitCnt_q + 4'd1;
                    if (bitCnt_q == LAST_STOP) frameDone_d = 1'b1;
                end else if (i_tick) begin
                    tickCnt_d = tickCnt_q + 1'b1;
                end
            end
            default: begin
                tickCnt_d = '0;
                bitCnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        parErr_d   = parErr_q;
        frameErr_d = frameErr_q;
        overrun_d  = 1'b0;
        if (frameDone_q) begin
            // A word still waiting for the consumer wins; the new frame is dropped.
            if (!valid_q || i_ready) begin
                data_d     = shift_q;
                valid_d    = 1'b1;
                parErr_d   = parErrPend_q;
                frameErr_d = frameErrPend_q;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tickCnt_q      <= '0;
            bitCnt_q       <= '0;
            shift_q        <= '0;
            mode_q         <= PAR_NONE;
            parErrPend_q   <= 1'b0;
            frameErrPend_q <= 1'b0;
            frameDone_q    <= 1'b0;
            data_q         <= '0;
            valid_q        <= 1'b0;
            parErr_q       <= 1'b0;
            frameErr_q     <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            tickCnt_q      <= tickCnt_d;
            bitCnt_q       <= bitCnt_d;
            shift_q        <= shift_d;
            mode_q         <= mode_d;
            parErrPend_q   <= parErrPend_d;
            frameErrPend_q <= frameErrPend_d;
            frameDone_q    <= frameDone_d;
            data_q         <= data_d;
            valid_q        <= valid_d;
            parErr_q       <= parErr_d;
            frameErr_q     <= frameErr_d;
            overrun_q      <= overrun_d;
        end
    end

    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_parity_err = parErr_q;
    assign o_frame_err  = frameErr_q;
    assign o_overrun    = overrun_q;

endmodule
